// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, ALU ops and sequencer states.
package cpu_ctrl_pkg;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_LOAD  = 4'b0010;
   localparam logic [3:0] OP_STORE = 4'b0011;
   localparam logic [3:0] OP_JUMP  = 4'b0100;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      FAULT
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_JUMP) || (op == OP_HALT);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait counter: counts stalled cycles of one access, flags when the limit is reached.
// WAIT_LIMIT = 0 disables the expired flag.
module wait_timer #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [W-1:0] LIMIT = W'(WAIT_LIMIT);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + W'(1);
      end
   end

   assign expired = (WAIT_LIMIT > 0) && (count == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Cycle-sequenced control for the 4-bit-opcode CPU: FETCH/DECODE/EXEC/MEM/WB with memory wait timeout.
// Strobes are Moore decodes of state; only FETCH/MEM completion is qualified by memReady.
module multicycle_sequencer #(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic             memReady,
   output logic             irWrite,
   output logic             pcWrite,
   output logic             pcSrc,
   output logic             memRead,
   output logic             memWrite,
   output logic             regWrite,
   output logic [1:0]       aluOp,
   output logic             jump,
   output logic             busy,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   import cpu_ctrl_pkg::*;

   state_t     state, state_nxt;
   logic [3:0] op_q;
   logic       in_wait;
   logic       expired;
   logic       retire;

   assign in_wait = (state == FETCH) || (state == MEM);

   // Cleared whenever no access is pending, so every FETCH/MEM entry starts from zero.
   wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (!in_wait || memReady),
      .inc     (in_wait && !memReady),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         op_q    <= '0;
         retired <= '0;
      end else begin
         state <= state_nxt;
         if (state == DECODE) begin
            op_q <= opcode;
         end
         if (retire) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      pcSrc     = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      aluOp     = ALU_ADD;
      jump      = 1'b0;
      retire    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = FETCH;
         end
         FETCH: begin
            memRead = 1'b1;
            if (memReady) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               state_nxt = DECODE;
            end else if (expired) begin
               state_nxt = FAULT;
            end
         end
         DECODE: begin
            if (opcode == OP_HALT) begin
               retire    = 1'b1;
               state_nxt = IDLE;
            end else if (!op_legal(opcode)) begin
               state_nxt = FAULT;
            end else begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            aluOp = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
            case (op_q)
               OP_ADD, OP_SUB:   state_nxt = WB;
               OP_LOAD, OP_STORE: state_nxt = MEM;
               OP_JUMP: begin
                  pcWrite   = 1'b1;
                  pcSrc     = 1'b1;
                  jump      = 1'b1;
                  retire    = 1'b1;
                  state_nxt = FETCH;
               end
               default: state_nxt = FAULT;
            endcase
         end
         MEM: begin
            memRead  = (op_q == OP_LOAD);
            memWrite = (op_q != OP_LOAD);
            if (memReady) begin
               if (op_q == OP_LOAD) begin
                  state_nxt = WB;
               end else begin
                  retire    = 1'b1;
                  state_nxt = FETCH;
               end
            end else if (expired) begin
               state_nxt = FAULT;
            end
         end
         WB: begin
            regWrite  = 1'b1;
            aluOp     = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
            retire    = 1'b1;
            state_nxt = FETCH;
         end
         FAULT: state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy  = (state != IDLE) && (state != FAULT);
   assign fault = (state == FAULT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: per-instruction cycle schedules expanded into an expected trace, checked every cycle.
module tb_multicycle_sequencer;

   localparam int CW = 4;
   localparam logic [3:0] B_ADD = 4'b0000, B_SUB = 4'b0001, B_LOAD = 4'b0010;
   localparam logic [3:0] B_STORE = 4'b0011, B_JUMP = 4'b0100, B_HALT = 4'b1111;
   localparam logic [3:0] JUNK = 4'b0111;

   typedef struct packed {
      logic ir, pc, pcs, mr, mw, rw;
      logic [1:0] alu;
      logic jmp, bsy, flt;
      logic [CW-1:0] ret;
   } outs_t;

   typedef struct {
      logic       rst, st, rdy;
      logic [3:0] op;
      outs_t      exp;
      string      tag;
   } cyc_t;

   logic clk = 1'b0;
   logic reset, start, memReady;
   logic [3:0] opcode;
   logic irWrite, pcWrite, pcSrc, memRead, memWrite, regWrite, jump, busy, fault;
   logic [1:0] aluOp;
   logic [CW-1:0] retired;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    ret_m   = 0;
   string tag_m   = "init";
   cyc_t  q[$];

   multicycle_sequencer #(.WAIT_LIMIT(15), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .memReady(memReady),
      .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .memRead(memRead),
      .memWrite(memWrite), .regWrite(regWrite), .aluOp(aluOp), .jump(jump),
      .busy(busy), .fault(fault), .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic void push(input logic rst, st, rdy, input logic [3:0] op,
                                input logic ir, pc, pcs, mr, mw, rw,
                                input logic [1:0] alu, input logic jmp, bsy, flt);
      cyc_t c;
      c.rst = rst; c.st = st; c.rdy = rdy; c.op = op; c.tag = tag_m;
      c.exp.ir = ir; c.exp.pc = pc; c.exp.pcs = pcs; c.exp.mr = mr; c.exp.mw = mw;
      c.exp.rw = rw; c.exp.alu = alu; c.exp.jmp = jmp; c.exp.bsy = bsy; c.exp.flt = flt;
      c.exp.ret = ret_m[CW-1:0];
      q.push_back(c);
   endfunction

   function automatic void retire_m();
      ret_m = (ret_m + 1) % (1 << CW);
   endfunction

   function automatic void idle(input int n, input logic st);
      for (int i = 0; i < n; i++) push(0, st, 1, JUNK, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
   endfunction

   function automatic void fault_cycles(input int n, input logic st);
      for (int i = 0; i < n; i++) push(0, st, 1, JUNK, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
   endfunction

   // Expected schedule of one instruction entered at FETCH; returns its cycle count.
   function automatic int instr(input logic [3:0] op, input int fw, input int mw);
      int n0 = q.size();
      logic [1:0] alu = (op == B_SUB) ? 2'b01 : 2'b00;
      for (int i = 0; i < fw; i++) push(0, 0, 0, JUNK, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0);
      push(0, 0, 1, JUNK, 1, 1, 0, 1, 0, 0, 2'b00, 0, 1, 0);
      push(0, 0, 1, op,   0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
      case (op)
         B_HALT: retire_m();
         B_ADD, B_SUB: begin
            push(0, 0, 1, JUNK, 0, 0, 0, 0, 0, 0, alu, 0, 1, 0);
            push(0, 0, 1, JUNK, 0, 0, 0, 0, 0, 1, alu, 0, 1, 0);
            retire_m();
         end
         B_LOAD: begin
            push(0, 0, 1, JUNK, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
            for (int i = 0; i < mw; i++) push(0, 0, 0, JUNK, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0);
            push(0, 0, 1, JUNK, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0);
            push(0, 0, 1, JUNK, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0);
            retire_m();
         end
         B_STORE: begin
            push(0, 0, 1, JUNK, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
            for (int i = 0; i < mw; i++) push(0, 0, 0, JUNK, 0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 0);
            push(0, 0, 1, JUNK, 0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 0);
            retire_m();
         end
         B_JUMP: begin
            push(0, 0, 1, JUNK, 0, 1, 1, 0, 0, 0, 2'b00, 1, 1, 0);
            retire_m();
         end
         default: ;
      endcase
      return q.size() - n0;
   endfunction

   function automatic void lit(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endfunction

   task automatic run_q();
      cyc_t  c;
      outs_t act;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(negedge clk);
         reset = c.rst; start = c.st; memReady = c.rdy; opcode = c.op;
         #1;
         act.ir = irWrite; act.pc = pcWrite; act.pcs = pcSrc; act.mr = memRead;
         act.mw = memWrite; act.rw = regWrite; act.alu = aluOp; act.jmp = jump;
         act.bsy = busy; act.flt = fault; act.ret = retired;
         n_tests++;
         if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b required %b (ir pc pcs mr mw rw alu jmp bsy flt ret)",
                     c.tag, $time, act, c.exp);
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; memReady = 1'b0; opcode = 4'h0;
      repeat (2) @(negedge clk);

      tag_m = "reset_add";
      idle(1, 0);
      idle(1, 1);
      lit("add_latency", instr(B_ADD, 0, 0), 4);
      lit("add_retired", ret_m, 1);
      tag_m = "halt_restart";
      lit("halt_latency", instr(B_HALT, 0, 0), 2);
      idle(1, 1);
      tag_m = "sub_load";
      lit("sub_latency", instr(B_SUB, 0, 0), 4);
      lit("load_latency_wait3", instr(B_LOAD, 0, 3), 8);
      lit("sub_load_retired", ret_m, 4);
      tag_m = "store_jump";
      lit("store_latency_waits", instr(B_STORE, 1, 2), 7);
      lit("jump_latency", instr(B_JUMP, 0, 0), 3);
      tag_m = "fetch_wait_limit";
      lit("add_fetch_wait15", instr(B_ADD, 15, 0), 19);
      lit("store_min_latency", instr(B_STORE, 0, 0), 4);
      lit("load_min_latency", instr(B_LOAD, 0, 0), 5);
      tag_m = "illegal";
      void'(instr(JUNK, 0, 0));
      fault_cycles(3, 1);
      run_q();
      lit("illegal_fault", fault, 1);
      lit("illegal_busy", busy, 0);
      lit("illegal_retired", retired, 9);

      tag_m = "fault_reset";
      push(1, 0, 1, JUNK, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
      ret_m = 0;
      idle(1, 0);
      tag_m = "timeout";
      idle(1, 1);
      for (int i = 0; i < 16; i++) push(0, 0, 0, JUNK, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0);
      fault_cycles(3, 1);
      run_q();
      lit("timeout_fault", fault, 1);
      lit("timeout_busy", busy, 0);

      tag_m = "halt";
      push(1, 0, 1, JUNK, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
      ret_m = 0;
      idle(1, 0);
      idle(1, 1);
      void'(instr(B_HALT, 0, 0));
      idle(2, 0);
      run_q();
      lit("halt_busy", busy, 0);
      lit("halt_retired", retired, 1);

      tag_m = "reset_in_mem";
      idle(1, 1);
      push(0, 0, 1, JUNK,   1, 1, 0, 1, 0, 0, 2'b00, 0, 1, 0);
      push(0, 0, 1, B_LOAD, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
      push(0, 0, 1, JUNK,   0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
      push(0, 0, 0, JUNK,   0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0);
      push(1, 0, 0, JUNK,   0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0);
      ret_m = 0;
      idle(2, 0);
      run_q();
      lit("reset_mem_memread", memRead, 0);
      lit("reset_mem_retired", retired, 0);

      tag_m = "wrap";
      idle(1, 1);
      for (int i = 0; i < 15; i++) begin
         case (i % 5)
            0: void'(instr(B_ADD, 0, 0));
            1: void'(instr(B_SUB, 1, 0));
            2: void'(instr(B_LOAD, 0, 1));
            3: void'(instr(B_STORE, 0, 0));
            default: void'(instr(B_JUMP, 0, 0));
         endcase
      end
      lit("wrap_model_15", ret_m, 15);
      void'(instr(B_HALT, 0, 0));
      idle(1, 0);
      run_q();
      lit("wrap_retired", retired, 0);
      lit("wrap_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
